// File: rtl/axi_pkg.sv
// Shared AXI response codes, responder FSM state encodings and burst limits.
package axi_pkg;

   localparam int MAX_BURST = 16;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   typedef logic [$clog2(MAX_BURST)-1:0] beat_t;

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI4 write/read channel bundle between a burst master and the memory responder.
interface axi_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [3:0]              awlen;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [3:0]              arlen;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  araddr, arlen, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );

   modport master (
      output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output araddr, arlen, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_mem_array.sv
// Byte-enabled word memory, one write port and one registered read port (1-cycle latency).
// A read and write to the same word on the same edge returns the old contents; no reset on storage.
module axi_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 16
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(MEM_WORDS)-1:0] widx,
   input  logic [DATA_WIDTH-1:0]        wdata,
   input  logic [DATA_WIDTH/8-1:0]      wstrb,
   input  logic                         re,
   input  logic [$clog2(MEM_WORDS)-1:0] ridx,
   output logic [DATA_WIDTH-1:0]        rdata
);
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[ridx];
   end
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 INCR burst memory responder, one outstanding burst per direction; read data 1 cycle after AR.
// Backpressure: all outputs hold while valid&!ready; bad beats are dropped and reported as SLVERR.
module axi_mem_responder
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 16
) (
   input logic                clk,
   input logic                rst,
   axi_mem_responder_if.slave bus
);
   localparam int                    IDX_W      = $clog2(MEM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_WORDS*4);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(4);

   // ---------------- write path ----------------
   w_state_t              w_state, w_next;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [3:0]            w_len;
   beat_t                 w_beat;
   logic                  w_mis, w_err;
   logic                  aw_hs, w_hs, b_hs, w_last_beat, w_beat_bad, w_last_bad;

   assign aw_hs       = bus.awvalid && (w_state == W_IDLE);
   assign w_hs        = bus.wvalid  && (w_state == W_DATA);
   assign b_hs        = bus.bready  && (w_state == W_RESP);
   assign w_last_beat = (w_beat == w_len);
   assign w_beat_bad  = w_mis || (w_addr >= ADDR_LIMIT);
   assign w_last_bad  = (bus.wlast != w_last_beat);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
         W_RESP:  if (b_hs) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      bus.awready = (w_state == W_IDLE);
      bus.wready  = (w_state == W_DATA);
      bus.bvalid  = (w_state == W_RESP);
      bus.bresp   = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;
   end

   // Burst length always follows awlen; a misplaced wlast only taints the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_addr <= '0;
         w_len  <= '0;
         w_beat <= '0;
         w_mis  <= 1'b0;
         w_err  <= 1'b0;
      end else if (aw_hs) begin
         w_addr <= bus.awaddr;
         w_len  <= bus.awlen;
         w_beat <= '0;
         w_mis  <= |bus.awaddr[1:0];
         w_err  <= |bus.awaddr[1:0];
      end else if (w_hs) begin
         w_addr <= w_addr + WORD_STEP;
         w_beat <= w_beat + beat_t'(1);
         if (w_beat_bad || w_last_bad) w_err <= 1'b1;
      end
   end

   // ---------------- read path ----------------
   r_state_t              r_state, r_next;
   logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
   logic [3:0]            r_len;
   beat_t                 r_beat;
   logic                  r_mis, r_err;
   logic                  ar_hs, r_hs, r_last_beat, mem_re;
   logic [IDX_W-1:0]      mem_ridx;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign ar_hs       = bus.arvalid && (r_state == R_IDLE);
   assign r_hs        = bus.rready  && (r_state == R_DATA);
   assign r_last_beat = (r_beat == r_len);
   assign r_addr_nxt  = r_addr + WORD_STEP;

   // Memory is read on the handshake that exposes the next beat, so rdata is fixed while stalled.
   assign mem_re   = ar_hs || (r_hs && !r_last_beat);
   assign mem_ridx = ar_hs ? bus.araddr[IDX_W+1:2] : r_addr_nxt[IDX_W+1:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      bus.arready = (r_state == R_IDLE);
      bus.rvalid  = (r_state == R_DATA);
      bus.rlast   = (r_state == R_DATA) && r_last_beat;
      bus.rresp   = ((r_state == R_DATA) && r_err) ? RESP_SLVERR : RESP_OKAY;
      bus.rdata   = ((r_state == R_DATA) && !r_err) ? mem_rdata : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_len  <= '0;
         r_beat <= '0;
         r_mis  <= 1'b0;
         r_err  <= 1'b0;
      end else if (ar_hs) begin
         r_addr <= bus.araddr;
         r_len  <= bus.arlen;
         r_beat <= '0;
         r_mis  <= |bus.araddr[1:0];
         r_err  <= (|bus.araddr[1:0]) || (bus.araddr >= ADDR_LIMIT);
      end else if (r_hs && !r_last_beat) begin
         r_addr <= r_addr_nxt;
         r_beat <= r_beat + beat_t'(1);
         r_err  <= r_mis || (r_addr_nxt >= ADDR_LIMIT);
      end
   end

   axi_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS)
   ) u_mem (
      .clk   (clk),
      .we    (w_hs && !w_beat_bad),
      .widx  (w_addr[IDX_W+1:2]),
      .wdata (bus.wdata),
      .wstrb (bus.wstrb),
      .re    (mem_re),
      .ridx  (mem_ridx),
      .rdata (mem_rdata)
   );
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed and randomized bursts against a word-array reference model of the 16-word memory.
module tb_axi_mem_responder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axi_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_mem_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] model  [16];
   logic [31:0] wbuf   [16];
   logic [3:0]  sbuf   [16];
   logic [31:0] rd_got [16];
   logic [1:0]  rr_got [16];
   logic [1:0]  b_got;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 awready, 1 wready, 2 bvalid, 3 arready
   task automatic wait_rdy(input string tag, input int which);
      logic s;
      int   g = 0;
      forever begin
         case (which)
            0:       s = bus.awready;
            1:       s = bus.wready;
            2:       s = bus.bvalid;
            default: s = bus.arready;
         endcase
         if (s === 1'b1) break;
         if (g == 40) begin
            check({tag, "_timeout"}, {31'd0, s}, 32'd1);
            break;
         end
         tick();
         g++;
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      check("rst_rvalid",  bus.rvalid,  0);
      check("rst_arready", bus.arready, 1);
      check("rst_awready", bus.awready, 1);
      check("rst_wready",  bus.wready,  0);
      check("rst_bvalid",  bus.bvalid,  0);
      check("rst_rdata",   bus.rdata,   0);
      @(negedge clk);
      rst = 1'b0;
      bus.rready = 1'b0;
      tick();
   endtask

   task automatic wr_burst(input logic [31:0] addr, input int len, input int last_idx,
                           input int abort_at, input bit gaps);
      bit          err;
      logic [31:0] a;
      err = (addr[1:0] != 2'b00);
      bus.awaddr  = addr;
      bus.awlen   = len[3:0];
      bus.awvalid = 1'b1;
      wait_rdy("awready", 0);
      tick();
      bus.awvalid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         if (b == abort_at) begin
            pulse_rst();
            return;
         end
         if (gaps && $urandom_range(0, 2) == 0) tick();
         bus.wdata  = wbuf[b];
         bus.wstrb  = sbuf[b];
         bus.wlast  = (b == last_idx);
         bus.wvalid = 1'b1;
         wait_rdy("wready", 1);
         if (b == len) check("no_early_bresp", bus.bvalid, 0);
         tick();
         bus.wvalid = 1'b0;
         bus.wlast  = 1'b0;
         a = addr + 32'(4*b);
         if (addr[1:0] != 2'b00 || a >= 32'd64) err = 1'b1;
         else begin
            for (int i = 0; i < 4; i++)
               if (sbuf[b][i]) model[a[5:2]][8*i +: 8] = wbuf[b][8*i +: 8];
         end
         if ((b == last_idx) != (b == len)) err = 1'b1;
      end
      wait_rdy("bvalid", 2);
      if ($urandom_range(0, 1) == 1) begin
         tick();
         check("bvalid_hold", bus.bvalid, 1);
      end
      b_got = bus.bresp;
      check("bresp", b_got, err ? 32'd2 : 32'd0);
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
      check("bvalid_clear", bus.bvalid, 0);
   endtask

   // mode: 0 rready always 1, 1 alternate 1,0,1,0..., 2 random
   task automatic rd_burst(input logic [31:0] addr, input int len, input int mode, input int abort_at);
      logic [31:0] a;
      bit          e, rr;
      int          b = 0;
      int          ph = 0;
      bus.araddr  = addr;
      bus.arlen   = len[3:0];
      bus.arvalid = 1'b1;
      wait_rdy("arready", 3);
      tick();
      bus.arvalid = 1'b0;
      check("rvalid_lat1", bus.rvalid, 1);
      while (b <= len && ph < 200) begin
         if (b == abort_at) begin
            pulse_rst();
            return;
         end
         a = addr + 32'(4*b);
         e = (addr[1:0] != 2'b00) || (a >= 32'd64);
         check("rvalid", bus.rvalid, 1);
         check("rdata",  bus.rdata,  e ? 32'd0 : model[a[5:2]]);
         check("rresp",  bus.rresp,  e ? 32'd2 : 32'd0);
         check("rlast",  bus.rlast,  (b == len) ? 32'd1 : 32'd0);
         rd_got[b] = bus.rdata;
         rr_got[b] = bus.rresp;
         case (mode)
            0:       rr = 1'b1;
            1:       rr = (ph % 2 == 0);
            default: rr = ($urandom_range(0, 1) == 1);
         endcase
         ph++;
         bus.rready = rr;
         tick();
         if (rr) b++;
      end
      bus.rready = 1'b0;
      check("arready_after", bus.arready, 1);
      check("rvalid_after",  bus.rvalid,  0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr;
      int          len;
      rst = 1'b1;
      bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_awready", bus.awready, 1);
      check("reset_arready", bus.arready, 1);
      check("reset_wready",  bus.wready,  0);
      check("reset_bvalid",  bus.bvalid,  0);
      check("reset_rvalid",  bus.rvalid,  0);
      check("reset_rlast",   bus.rlast,   0);
      check("reset_bresp",   bus.bresp,   0);
      check("reset_rresp",   bus.rresp,   0);
      check("reset_rdata",   bus.rdata,   0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // prefill whole memory so the model is fully defined
      for (int i = 0; i < 16; i++) begin
         wbuf[i] = $urandom;
         sbuf[i] = 4'hF;
      end
      wr_burst(32'h0, 15, 15, -1, 1'b0);
      rd_burst(32'h0, 15, 0, -1);

      // single beat write/read
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      wr_burst(32'h8, 0, 0, -1, 1'b0);
      check("single_bresp", b_got, 0);
      rd_burst(32'h8, 0, 0, -1);
      check("single_rdata", rd_got[0], 32'hDEADBEEF);
      check("single_rresp", rr_got[0], 0);

      // 4-beat burst, read back with rready 1,0,1,0
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = 32'(i + 1);
         sbuf[i] = 4'hF;
      end
      wr_burst(32'h0, 3, 3, -1, 1'b0);
      rd_burst(32'h0, 3, 1, -1);
      for (int i = 0; i < 4; i++) check("burst4_rdata", rd_got[i], 32'(i + 1));

      // partial strobe
      wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
      wr_burst(32'h10, 0, 0, -1, 1'b0);
      wbuf[0] = 32'h12345678; sbuf[0] = 4'h3;
      wr_burst(32'h10, 0, 0, -1, 1'b0);
      rd_burst(32'h10, 0, 0, -1);
      check("strobe_rdata", rd_got[0], 32'hFFFF5678);

      // burst running off the end of memory
      for (int i = 0; i < 4; i++) begin
         wbuf[i] = $urandom;
         sbuf[i] = 4'hF;
      end
      wr_burst(32'h38, 3, 3, -1, 1'b0);
      check("oob_bresp", b_got, 2);
      rd_burst(32'h38, 3, 0, -1);
      check("oob_rresp0", rr_got[0], 0);
      check("oob_rresp1", rr_got[1], 0);
      check("oob_rresp2", rr_got[2], 2);
      check("oob_rresp3", rr_got[3], 2);
      check("oob_rdata2", rd_got[2], 0);
      check("oob_rdata3", rd_got[3], 0);

      // early wlast on the second beat
      wr_burst(32'h20, 3, 1, -1, 1'b0);
      check("wlast_bresp", b_got, 2);
      rd_burst(32'h20, 3, 0, -1);

      // misaligned burst is dropped entirely
      wr_burst(32'h6, 1, 1, -1, 1'b0);
      check("misalign_bresp", b_got, 2);
      rd_burst(32'h6, 1, 0, -1);
      check("misalign_rresp", rr_got[0], 2);
      rd_burst(32'h4, 1, 0, -1);

      // reset during beat 2 of a read, then during a write
      rd_burst(32'h0, 3, 0, 2);
      rd_burst(32'h0, 3, 0, -1);
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      wr_burst(32'h24, 3, 3, 2, 1'b0);
      rd_burst(32'h20, 4, 0, -1);

      // concurrent write and read on disjoint halves
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = 4'($urandom_range(0, 15));
         end
         fork
            wr_burst(32'h0, 7, 7, -1, 1'b1);
            rd_burst(32'h20, 7, 2, -1);
         join
         rd_burst(32'h0, 7, 2, -1);
      end

      // randomized bursts
      for (int k = 0; k < 12; k++) begin
         addr = 32'($urandom_range(0, 19) * 4);
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
         len = $urandom_range(0, 15);
         for (int i = 0; i < 16; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = 4'($urandom_range(0, 15));
         end
         wr_burst(addr, len, len, -1, 1'b1);
         addr = 32'($urandom_range(0, 19) * 4);
         if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
         rd_burst(addr, $urandom_range(0, 15), 2, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI data width (32 only supported).
REQ-003 SHALL have parameter MEM_WORDS, default 16, number of internal DATA_WIDTH words (power of 2).
REQ-004 SHALL have ports:
- clk, input, 1, sole clock; all logic rising-edge.
- rst, input, 1, asynchronous active-high reset.
- awaddr / awlen / awvalid, input, ADDR_WIDTH/4/1, write address channel.
- awready, output, 1, write address accept.
- wdata / wstrb / wlast / wvalid, input, DATA_WIDTH/DATA_WIDTH/8/1/1, write data channel.
- wready, output, 1, write data accept.
- bresp / bvalid, output, 2/1, write response; bready, input, 1.
- araddr / arlen / arvalid, input, ADDR_WIDTH/4/1, read address channel.
- arready, output, 1, read address accept.
- rdata / rresp / rlast / rvalid, output, DATA_WIDTH/2/1/1, read data channel; rready, input, 1.

Function
REQ-005 SHALL be an AXI4 INCR-burst responder, 1-16 beats (len+1), one outstanding transaction per direction; write and read paths independent and concurrent.
REQ-006 Handshake SHALL occur on a rising edge with valid&ready both high; outputs SHALL hold stable while valid is high and ready low.
REQ-007 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; wready=1 only in W_DATA; bvalid=1 only in W_RESP.
REQ-008 W_IDLE->W_DATA on AW handshake (latch addr, len, clear error); W_DATA->W_RESP on handshake of beat len; W_RESP->W_IDLE on bready.
REQ-009 Each W beat SHALL write bytes enabled by wstrb to word index addr[log2(MEM_WORDS)+1:2]; address SHALL advance by 4 per beat.
REQ-010 Beat whose word address >= MEM_WORDS*4 SHALL be dropped and flag SLVERR; awaddr[1:0]!=0 SHALL flag SLVERR and drop the whole burst.
REQ-011 wlast SHALL be checked: wlast high before beat len, or low on beat len, flags SLVERR; burst length SHALL still follow awlen.
REQ-012 bresp SHALL be 2'b00 OKAY, or 2'b10 SLVERR if any error flagged.
REQ-013 Read FSM SHALL have states R_IDLE, R_DATA; arready=1 only in R_IDLE; AR handshake latches addr/len and enters R_DATA.
REQ-014 First rvalid SHALL assert the cycle after AR handshake (latency 1); subsequent beats SHALL follow back-to-back while rready=1.
REQ-015 rlast SHALL be 1 exactly on beat len; R_DATA->R_IDLE on handshake of that beat; arready reasserted the next cycle.
REQ-016 Out-of-range or misaligned read beats SHALL return rdata=0, rresp=SLVERR; others rresp=OKAY.
REQ-017 A write and read to the same word in the same cycle SHALL return the pre-write value to the read.
REQ-018 No write response SHALL be issued before the last W beat is accepted.

Reset
REQ-019 While rst=1, both FSMs SHALL be IDLE, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, rdata=0.
REQ-020 Reset mid-burst SHALL abandon the burst without response; memory contents SHALL be retained (not reset).
REQ-021 Reset SHALL take effect immediately and release synchronously to clk.

Structure
REQ-022 Response codes (OKAY, SLVERR), FSM state enums and MAX_BURST=16 SHALL live in shared package axi_pkg.
REQ-023 Storage SHALL be one sub-module axi_mem_array (byte-enabled write port, async/registered read port, MEM_WORDS deep).

Verification
REQ-024 Single write awaddr=0x8, wdata=0xDEADBEEF, wstrb=0xF, then read araddr=0x8 -> bresp=OKAY, rdata=0xDEADBEEF, rlast=1.
REQ-025 4-beat write at 0x0 data 1,2,3,4, read len=3 with rready toggling 1,0,1,0 -> rdata 1,2,3,4 held stable while stalled, rlast on beat 4 only.
REQ-026 Write wstrb=0x3 data 0x12345678 over 0xFFFFFFFF -> readback 0xFFFF5678.
REQ-027 Burst at 0x38 len=3 (MEM_WORDS=16) -> first 2 beats written, bresp=SLVERR; read same -> rresp OKAY,OKAY,SLVERR,SLVERR, last two rdata=0.
REQ-028 wlast asserted on beat 2 of len=3 burst -> 4 beats still accepted, bresp=SLVERR.
REQ-029 rst pulsed during beat 2 of a read burst -> rvalid=0 immediately, arready=1, earlier-written data still readable.
